// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM port controller.
//   RAM_LAT_DEFAULT : default read latency of the attached synchronous RAM
//   count_ones      : population count helper used for read credit tracking
package ram_ctrl_pkg;

    localparam int unsigned RAM_LAT_DEFAULT = 2;

    // Widest tracking vector the helper accepts; callers zero-extend.
    localparam int unsigned ONES_MAX = 32;

    function automatic int unsigned count_ones(input logic [ONES_MAX-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < ONES_MAX; i++) begin
            n = n + {31'b0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/ram_rsp_fifo.sv
// Synchronous response FIFO with first-word-fall-through head.
//   clk, reset      : rising-edge clock, asynchronous active-high reset
//   push, push_data : enqueue one word
//   pop             : dequeue the head word (ignored when empty)
//   head            : current head word, valid whenever empty is low
//   count, empty    : occupancy
module ram_rsp_fifo #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 4,
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [CNT_W-1:0]      count,
    output logic                  empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      cnt;
    logic                  full;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only legal if the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + 1'b1;
            end else if (do_pop && !do_push) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_port_controller.sv
// Request/response front end for a single-port synchronous RAM.
//   clk, reset                     : rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready            : command handshake; req_we selects write (1) or read (0)
//   req_addr, req_wdata            : command address and write data
//   rsp_valid/rsp_ready, rsp_data  : read responses in issue order
//   ram_we, ram_addr, ram_data     : registered RAM port
//   ram_q                          : RAM read data
//   idle                           : no read in flight and no buffered response
module ram_port_controller
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned RAM_LAT    = RAM_LAT_DEFAULT,
    parameter int unsigned RSP_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic                  idle
);

    // Stage 0 is aligned with the registered RAM port; the remaining stages cover
    // the RAM address sample edge plus RAM_LAT, so the last stage lines up with ram_q.
    localparam int unsigned PIPE_LEN = RAM_LAT + 2;
    localparam int unsigned CNT_W    = $clog2(RSP_DEPTH + 1);
    localparam int unsigned CREDIT_W = $clog2(PIPE_LEN + RSP_DEPTH + 1);

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } ram_req_t;

    ram_req_t              port_q;
    logic [PIPE_LEN-1:0]   rd_pipe_q;
    logic                  live_q;
    logic                  accept;
    logic                  rsp_push;
    logic                  rsp_pop;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic [CREDIT_W-1:0]   inflight;
    logic [CREDIT_W-1:0]   credits_used;

    assign accept = req_valid && req_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            port_q    <= '0;
            rd_pipe_q <= '0;
            live_q    <= 1'b0;
        end else begin
            live_q <= 1'b1;
            if (accept) begin
                port_q.we    <= req_we;
                port_q.addr  <= req_addr;
                port_q.wdata <= req_wdata;
            end else begin
                port_q.we <= 1'b0;
            end
            rd_pipe_q <= {rd_pipe_q[PIPE_LEN-2:0], accept && !req_we};
        end
    end

    // Every read holds a credit from acceptance until its response is popped,
    // so the FIFO can never be pushed while full.
    assign inflight     = CREDIT_W'(count_ones(ONES_MAX'(rd_pipe_q)));
    assign credits_used = inflight + CREDIT_W'(fifo_count);
    assign req_ready    = live_q && (credits_used < CREDIT_W'(RSP_DEPTH));

    assign rsp_push  = rd_pipe_q[PIPE_LEN-1];
    assign rsp_valid = !fifo_empty;
    assign rsp_pop   = rsp_valid && rsp_ready;

    ram_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (RSP_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rsp_push),
        .push_data (ram_q),
        .pop       (rsp_pop),
        .head      (rsp_data),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign ram_we   = port_q.we;
    assign ram_addr = port_q.addr;
    assign ram_data = port_q.wdata;
    assign idle     = (inflight == '0) && fifo_empty;

endmodule

// File: tb/tb_ram_port_controller.sv
// Bench for ram_port_controller with a behavioural RAM and a transaction-level
// reference model checked every cycle, plus directed literal expectations.
module tb_ram_port_controller;

    localparam int unsigned DW          = 16;
    localparam int unsigned AW          = 5;
    localparam int unsigned RL          = 2;
    localparam int unsigned DEPTH       = 4;
    localparam int unsigned ACC_TO_PUSH = RL + 2;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_we    = 1'b0;
    logic [AW-1:0] req_addr  = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_ready = 1'b0;
    logic          req_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic [DW-1:0] ram_q;
    logic          idle;

    always #5 clk = ~clk;

    ram_port_controller #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .RAM_LAT    (RL),
        .RSP_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .ram_q     (ram_q),
        .idle      (idle)
    );

    // RAM: samples addr/we on an edge, ram_q holds that word RL edges later.
    logic [DW-1:0] ram_mem  [1 << AW];
    logic [DW-1:0] ram_pipe [RL + 1];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_data;
        ram_pipe[0] <= ram_mem[ram_addr];
        for (int i = 1; i <= int'(RL); i++) ram_pipe[i] <= ram_pipe[i-1];
    end
    assign ram_q = ram_pipe[RL];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: reads are queued with the edge on which their data lands in the
    // response buffer; credits are reads pending plus buffered responses.
    typedef struct {
        int unsigned   due;
        logic [DW-1:0] data;
    } pend_t;

    pend_t         m_pend[$];
    logic [DW-1:0] m_fifo[$];
    logic [DW-1:0] m_mem [1 << AW];
    logic          m_ready = 1'b0;
    logic          m_we    = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_data  = '0;
    int unsigned   cyc     = 0;
    logic [DW-1:0] dut_log[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pend.delete();
            m_fifo.delete();
            m_ready = 1'b0;
            m_we    = 1'b0;
            m_addr  = '0;
            m_data  = '0;
        end else begin
            cyc++;
            if (rsp_valid && rsp_ready) dut_log.push_back(rsp_data);
            if (dut.rsp_push) check("no_push_when_full", 32'(dut.fifo_count == 3'(DEPTH)), 32'd0);
            if (m_fifo.size() != 0 && rsp_ready) void'(m_fifo.pop_front());
            while (m_pend.size() != 0 && m_pend[0].due == cyc) begin
                m_fifo.push_back(m_pend[0].data);
                void'(m_pend.pop_front());
            end
            if (req_valid && m_ready) begin
                m_we   = req_we;
                m_addr = req_addr;
                m_data = req_wdata;
                if (req_we) m_mem[req_addr] = req_wdata;
                else m_pend.push_back('{cyc + ACC_TO_PUSH, m_mem[req_addr]});
            end else begin
                m_we = 1'b0;
            end
            m_ready = (m_pend.size() + m_fifo.size()) < int'(DEPTH);
        end
    end

    always @(negedge clk) begin
        check("req_ready", 32'(req_ready), 32'(m_ready));
        check("rsp_valid", 32'(rsp_valid), 32'(m_fifo.size() != 0));
        if (m_fifo.size() != 0) check("rsp_data", 32'(rsp_data), 32'(m_fifo[0]));
        check("idle", 32'(idle), 32'(m_fifo.size() == 0 && m_pend.size() == 0));
        check("ram_we", 32'(ram_we), 32'(m_we));
        check("ram_addr", 32'(ram_addr), 32'(m_addr));
        check("ram_data", 32'(ram_data), 32'(m_data));
    end

    // Called at a negedge; returns at the negedge after the command is accepted.
    task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] d);
        int guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("issue_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic wait_rsp(input int max, output int n);
        n = 0;
        while (!rsp_valid && n < max) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (!idle && n < max) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", 32'(idle), 32'd1);
    endtask

    int nxt;
    logic take;
    task automatic offer_cycle(input int base, input int total);
        take = req_valid && req_ready;
        @(negedge clk);
        if (take) nxt++;
        req_valid = (nxt < total);
        req_addr  = AW'(base + nxt);
    endtask

    int n;

    initial begin
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("release_req_ready", 32'(req_ready), 32'd1);
        check("release_idle", 32'(idle), 32'd1);
        @(negedge clk);

        // Reset pulse mid-clock with a buffered response present.
        issue(1'b1, 5'd7, 16'h1234);
        issue(1'b0, 5'd7, 16'h0);
        wait_rsp(20, n);
        check("pre_rst_rsp_data", 32'(rsp_data), 32'h1234);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_rsp_data", 32'(rsp_data), 32'd0);
        check("midrst_ram_we", 32'(ram_we), 32'd0);
        check("midrst_ram_addr", 32'(ram_addr), 32'd0);
        check("midrst_ram_data", 32'(ram_data), 32'd0);
        check("midrst_idle", 32'(idle), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_release_ready", 32'(req_ready), 32'd1);
        @(negedge clk);

        // Write then read back on the next cycle.
        dut_log.delete();
        issue(1'b1, 5'd3, 16'hBEEF);
        issue(1'b0, 5'd3, 16'h0);
        wait_rsp(20, n);
        check("rd_latency", 32'(n), 32'd4);
        check("rd_data", 32'(rsp_data), 32'hBEEF);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rd_log_size", 32'(dut_log.size()), 32'd1);
        if (dut_log.size() == 1) check("rd_log_data", 32'(dut_log[0]), 32'hBEEF);
        check("rd_idle", 32'(idle), 32'd1);

        // Streaming writes then back-to-back reads.
        for (int a = 0; a < 32; a++) issue(1'b1, AW'(a), DW'(a * 3));
        dut_log.delete();
        rsp_ready = 1'b1;
        for (int a = 0; a < 32; a++) issue(1'b0, AW'(a), '0);
        wait_idle(40);
        rsp_ready = 1'b0;
        check("stream_count", 32'(dut_log.size()), 32'd32);
        for (int i = 0; i < dut_log.size(); i++) check("stream_data", 32'(dut_log[i]), 32'(i * 3));

        // Backpressure: six reads offered with the consumer stalled.
        dut_log.delete();
        nxt       = 0;
        req_we    = 1'b0;
        req_addr  = 5'd10;
        req_valid = 1'b1;
        repeat (12) offer_cycle(10, 6);
        check("bp_accepted", 32'(nxt), 32'd4);
        check("bp_req_ready", 32'(req_ready), 32'd0);
        check("bp_head", 32'(rsp_data), 32'd30);
        rsp_ready = 1'b1;
        offer_cycle(10, 6);
        rsp_ready = 1'b0;
        check("bp_ready_after_pop", 32'(req_ready), 32'd1);
        check("bp_head_after_pop", 32'(rsp_data), 32'd33);
        rsp_ready = 1'b1;
        repeat (16) offer_cycle(10, 6);
        wait_idle(20);
        rsp_ready = 1'b0;
        check("bp_total", 32'(nxt), 32'd6);
        check("bp_log_size", 32'(dut_log.size()), 32'd6);
        for (int i = 0; i < dut_log.size(); i++) check("bp_order", 32'(dut_log[i]), 32'(30 + 3 * i));

        // Push and pop on the same edge with two entries buffered.
        dut_log.delete();
        issue(1'b0, 5'd20, '0);
        issue(1'b0, 5'd21, '0);
        issue(1'b0, 5'd22, '0);
        repeat (3) @(negedge clk);
        check("pp_count_before", 32'(dut.fifo_count), 32'd2);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("pp_count_same", 32'(dut.fifo_count), 32'd2);
        check("pp_head", 32'(rsp_data), 32'd63);
        wait_idle(20);
        rsp_ready = 1'b0;
        check("pp_log_size", 32'(dut_log.size()), 32'd3);
        for (int i = 0; i < dut_log.size(); i++) check("pp_order", 32'(dut_log[i]), 32'(60 + 3 * i));

        // Reset while three reads are in flight.
        dut_log.delete();
        issue(1'b0, 5'd5, '0);
        issue(1'b0, 5'd6, '0);
        issue(1'b0, 5'd7, '0);
        #2 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            check("flush_no_rsp", 32'(rsp_valid), 32'd0);
            @(negedge clk);
        end
        issue(1'b0, 5'd9, '0);
        wait_rsp(20, n);
        check("post_flush_latency", 32'(n), 32'd4);
        check("post_flush_data", 32'(rsp_data), 32'd27);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_flush_log", 32'(dut_log.size()), 32'd1);
        check("post_flush_idle", 32'(idle), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected completion by 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
